// File: rtl/mem_arbiter.sv
// Two-port (fetch / LSU) arbiter onto a single memory port with one transaction
// in flight. LSU is preferred under contention, but fetch wins after two LSU wins in a row.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic {OWN_IF, OWN_LSU} owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [1:0]  streak_q, streak_d;

    logic lsu_wins;
    logic capture;

    // Fetch only overtakes a contending LSU once the LSU has won twice in a row.
    assign lsu_wins = lsu_req_i & (~if_req_i | (streak_q != 2'd2));
    assign capture  = (state_q == IDLE) & (if_req_i | lsu_req_i) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = REQ;
            REQ:     if (mem_gnt_i) state_d = RESP;
            RESP:    if (mem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o     = capture & ~lsu_wins;
        lsu_gnt_o    = capture & lsu_wins;
        if_rvalid_o  = ~rst & (state_q == RESP) & mem_rvalid_i & (owner_q == OWN_IF);
        lsu_rvalid_o = ~rst & (state_q == RESP) & mem_rvalid_i & (owner_q == OWN_LSU);
        mem_req_o    = (state_q == REQ);
        busy_o       = (state_q != IDLE);
    end

    always_comb begin
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        streak_d = streak_q;
        if (capture) begin
            if (lsu_wins) begin
                owner_d  = OWN_LSU;
                addr_d   = lsu_addr_i;
                wdata_d  = lsu_wdata_i;
                be_d     = lsu_be_i;
                we_d     = lsu_we_i;
                streak_d = if_req_i ? ((streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1) : 2'd0;
            end else begin
                owner_d  = OWN_IF;
                addr_d   = if_addr_i;
                be_d     = 4'hF;
                we_d     = 1'b0;
                streak_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            streak_q <= streak_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as below.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  32  fetch address
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- lsu_req_i  in  1  LSU request
- lsu_we_i  in  1  1=store, 0=load
- lsu_be_i  in  4  store byte enables
- lsu_addr_i  in  32  LSU address
- lsu_wdata_i  in  32  store data
- lsu_gnt_o  out  1  LSU request accepted
- lsu_rvalid_o  out  1  load data valid, or store done
- lsu_rdata_o  out  32  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory response (read data or write ack)
- mem_rdata_i  in  32  memory read data
- busy_o  out  1  transaction in flight

Function
REQ-002 The block SHALL implement an FSM with states IDLE, REQ and RESP, and SHALL allow only one outstanding memory transaction.
REQ-003 In IDLE with at least one request, the block SHALL choose a winner and assert its gnt_o combinationally in that cycle.
- It SHALL latch owner, addr, we, be and wdata into registers.
- It SHALL move to REQ next cycle.
- Fetch captures force we=0 and be=4'hF.
REQ-004 Requesters MAY drop req_i or change their inputs after the gnt_o cycle; the latched values SHALL remain unaffected.
REQ-005 Arbitration rules:
- If only one requester is active, it SHALL win.
- If both are active, the LSU SHALL win, unless lsu_streak==2, in which case fetch SHALL win.
REQ-006 lsu_streak (2-bit, saturating at 2) SHALL update on each capture:
- increment when LSU wins while if_req_i=1;
- clear when fetch wins;
- clear when LSU wins while if_req_i=0.
REQ-007 In REQ, mem_req_o SHALL be 1 and the mem_* outputs SHALL be driven from the latched registers.
- On mem_gnt_i=1 the FSM SHALL go to RESP.
- Otherwise it SHALL hold REQ with stable outputs.
REQ-008 In RESP, mem_req_o SHALL be 0. On mem_rvalid_i=1:
- the owner's rvalid_o SHALL pulse combinationally in that cycle;
- the FSM SHALL return to IDLE.
REQ-009 if_rdata_o and lsu_rdata_o SHALL both pass through mem_rdata_i unconditionally; only the rvalid_o outputs SHALL be owner-gated.
REQ-010 mem_rvalid_i SHALL be ignored in IDLE and REQ, including when it is asserted together with mem_gnt_i.
REQ-011 No gnt_o SHALL be asserted outside IDLE; a new capture SHALL be possible no earlier than the cycle after the rvalid cycle.
REQ-012 Minimum latency (req_i asserted at cycle N, zero-wait memory):
- gnt_o at N;
- mem_req_o at N+1;
- rvalid_o at N+2;
- next gnt_o at N+3.
REQ-013 busy_o SHALL be 1 exactly when the state is REQ or RESP.
REQ-014 When the block is idle and no request is present, all mem_* outputs SHALL hold their last latched values; only mem_req_o is meaningful.

Reset
REQ-015 On rst=1 at a clock edge, the block SHALL take the following values from the next cycle:
- state=IDLE, lsu_streak=0;
- latched address, wdata and be = 0, we=0, owner=fetch;
- mem_req_o=0, busy_o=0.
REQ-016 While rst=1, gnt_o and rvalid_o outputs SHALL be 0.
REQ-017 Reset in REQ or RESP SHALL abandon the transaction; a late mem_rvalid_i after reset SHALL be ignored.

Verification
REQ-018 Single fetch: if_req_i=1, if_addr_i=0x100, mem_gnt_i=1, and at the next cycle mem_rvalid_i=1 with mem_rdata_i=0xDEADBEEF.
- Expected: if_gnt_o at N, mem_addr_o=0x100 with we=0 and be=F at N+1, if_rvalid_o with 0xDEADBEEF at N+2.
REQ-019 Store with a wait state: lsu_we_i=1, be=0x3, addr=0x200, wdata=0x1234, mem_gnt_i held 0 for 3 cycles.
- Expected: mem_req_o held 4 cycles with stable outputs, and lsu_rvalid_o only after mem_rvalid_i.
REQ-020 Contention: if_req_i and lsu_req_i held 1 continuously.
- Expected grant order: LSU, LSU, IF, LSU, LSU, IF.
REQ-021 Spurious response: mem_rvalid_i=1 in IDLE and in REQ.
- Expected: no rvalid_o asserted and no state change.
REQ-022 Reset mid-transaction: rst=1 in RESP, then mem_rvalid_i=1.
- Expected: mem_req_o=0, busy_o=0, no rvalid_o, and the next if_req_i granted normally.
